// File: rtl/candle_sequencer.sv
// candle_sequencer
// Command-side master for the candle register bank. Takes a target 8-bit mask
// over a valid/ready handshake and diffs it against the live bank state. It
// then drives the minimum set/clear strobe sequence, issuing at most one set
// and one clear per cycle. After a settle window it verifies the result,
// retries on mismatch and pulses done or error.
//
// Parameters
//   SETTLE_CYCLES  idle cycles between the last command and verification (1..15)
//   MAX_RETRY      re-issue attempts after a failed verification (0..7)
// Ports
//   sys_clk        clock, rising edge
//   clr            synchronous active-high reset
//   req_valid      target request valid
//   req_ready      high in IDLE; request accepted on req_valid && req_ready
//   req_mask       target candle pattern, sampled at acceptance
//   candle_state   live bank state feedback
//   pos_to_set     set position (0 when set_enable is low)
//   set_enable     set strobe, one cycle per position
//   pos_to_clear   clear position (0 when clear_enable is low)
//   clear_enable   clear strobe, one cycle per position
//   busy           high whenever not IDLE
//   done           one-cycle pulse on successful verification
//   error          one-cycle pulse when retries are exhausted
module candle_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned MAX_RETRY     = 2
) (
    input  logic       sys_clk,
    input  logic       clr,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_mask,
    input  logic [7:0] candle_state,
    output logic [2:0] pos_to_set,
    output logic       set_enable,
    output logic [2:0] pos_to_clear,
    output logic       clear_enable,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [1:0] {StIdle, StIssue, StSettle, StCheck} state_e;

    state_e     state_q, state_d;
    logic [7:0] target_q, target_d;
    logic [7:0] pend_set_q, pend_set_d;
    logic [7:0] pend_clr_q, pend_clr_d;
    logic [2:0] retry_q, retry_d;
    logic [3:0] cnt_q, cnt_d;
    logic       done_q, done_d;
    logic       error_q, error_d;

    // Index of the lowest set bit; 0 for an all-zero vector.
    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        pend_set_d   = pend_set_q;
        pend_clr_d   = pend_clr_q;
        retry_d      = retry_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        error_d      = 1'b0;
        set_enable   = 1'b0;
        pos_to_set   = 3'd0;
        clear_enable = 1'b0;
        pos_to_clear = 3'd0;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    target_d   = req_mask;
                    pend_set_d = req_mask & ~candle_state;
                    pend_clr_d = ~req_mask & candle_state;
                    retry_d    = 3'd0;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                if (pend_set_q != 8'd0) begin
                    set_enable = 1'b1;
                    pos_to_set = lowest_idx(pend_set_q);
                end
                if (pend_clr_q != 8'd0) begin
                    clear_enable = 1'b1;
                    pos_to_clear = lowest_idx(pend_clr_q);
                end
                // v & (v - 1) drops the lowest set bit (no-op on zero).
                pend_set_d = pend_set_q & (pend_set_q - 8'd1);
                pend_clr_d = pend_clr_q & (pend_clr_q - 8'd1);
                if (pend_set_d == 8'd0 && pend_clr_d == 8'd0) begin
                    state_d = StSettle;
                    cnt_d   = 4'(SETTLE_CYCLES);
                end
            end
            StSettle: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = StCheck;
            end
            StCheck: begin
                if (candle_state == target_q) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (retry_q < 3'(MAX_RETRY)) begin
                    pend_set_d = target_q & ~candle_state;
                    pend_clr_d = ~target_q & candle_state;
                    retry_d    = retry_q + 3'd1;
                    state_d    = StIssue;
                end else begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (clr) begin
            state_q    <= StIdle;
            target_q   <= 8'd0;
            pend_set_q <= 8'd0;
            pend_clr_q <= 8'd0;
            retry_q    <= 3'd0;
            cnt_q      <= 4'd0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            pend_set_q <= pend_set_d;
            pend_clr_q <= pend_clr_d;
            retry_q    <= retry_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: doc/candle_sequencer.md
# candle_sequencer

Command-side master for the candle register bank. Accepts a target 8-bit candle mask over a valid/ready handshake and compares it against the live `candle_state` feedback. It then issues the minimum sequence of single-position set and clear commands on the bank's set/clear ports, running up to one set and one clear per cycle. After a settle window it verifies the result, retries on mismatch, and reports done or error.

## Interface
- `SETTLE_CYCLES`, default 1: idle cycles between the last command and verification; legal range 1..15.
- `MAX_RETRY`, default 2: re-issue attempts after a failed verification; legal range 0..7.

- `sys_clk`  in  1  single clock; all state updates on rising edge.
- `clr`  in  1  reset; synchronous, active-high.
- `req_valid`  in  1  target mask request valid.
- `req_ready`  out  1  high only in IDLE; the request is accepted on an edge where `req_valid && req_ready`.
- `req_mask`  in  8  target candle pattern; sampled at acceptance only.
- `candle_state`  in  8  live bank state (feedback).
- `pos_to_set`  out  3  set position; 0 when `set_enable`=0.
- `set_enable`  out  1  set command strobe; one cycle per position.
- `pos_to_clear`  out  3  clear position; 0 when `clear_enable`=0.
- `clear_enable`  out  1  clear command strobe; one cycle per position.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse on successful verification.
- `error`  out  1  one-cycle pulse when retries are exhausted.

## Operation
- State machine: IDLE, ISSUE, SETTLE, CHECK.
- **IDLE, on acceptance:**
  - Latch `target`=`req_mask`.
  - Set `pend_set`=`req_mask & ~candle_state`.
  - Set `pend_clr`=`~req_mask & candle_state`.
  - Set `retry`=0 and go to ISSUE.
- **ISSUE, set side:** if `pend_set`≠0, drive `set_enable`=1 and `pos_to_set`=index of the lowest set bit of `pend_set`, then clear that bit at the edge.
- **ISSUE, clear side:** the same lowest-bit-first rule applies independently and in parallel to `pend_clr`, `pos_to_clear` and `clear_enable`.
- **ISSUE, exit:**
  - ISSUE lasts max(N,1) cycles, where N = max(popcount(`pend_set`), popcount(`pend_clr`)).
  - When both pending masks are zero after the edge, go to SETTLE with the counter loaded to `SETTLE_CYCLES`.
  - A zero-change request spends one ISSUE cycle with no strobes.
- Command outputs are decoded from the pending registers and the state. They are stable for the whole cycle, and both enables are 0 outside ISSUE.
- `pend_set` and `pend_clr` are disjoint by construction, so a position is never set and cleared in the same cycle.
- **SETTLE:** decrement the counter each cycle; go to CHECK when it reaches 1.
- **CHECK (one cycle):**
  - If `candle_state`==`target`: go to IDLE with `done` set for the next cycle.
  - Else if `retry`<`MAX_RETRY`: recompute `pend_set`/`pend_clr` from the current `candle_state`, increment `retry`, and go to ISSUE.
  - Else: go to IDLE with `error` set for the next cycle.
- `done` and `error` are registered and never high together. They coincide with the first IDLE cycle, during which `req_ready`=1.
- `req_mask` changes after acceptance are ignored. `req_valid` while busy is ignored, with no queuing.

## Timing
- Reset values: `req_ready`=1, `busy`=0, `done`=0, `error`=0, `set_enable`=0, `clear_enable`=0, `pos_to_set`=0, `pos_to_clear`=0, all internal registers 0, state IDLE.
- Acceptance occurs at edge 0. Commands are driven in cycles 1..max(N,1).
- SETTLE occupies the next `SETTLE_CYCLES` cycles, followed by one CHECK cycle.
- `done`/`error` is high in the following cycle. Minimum request-to-done latency is max(N,1)+`SETTLE_CYCLES`+2 cycles.
- The bank updates one edge after a strobe, so `SETTLE_CYCLES`≥1 guarantees CHECK sees the final command's effect.
- `clr` asserted at any edge, including mid-ISSUE:
  - next cycle is IDLE with all outputs at reset values;
  - no `done` or `error` pulse;
  - the partially issued sequence is abandoned.
- `clr` takes priority over acceptance in the same cycle.

## Test plan
- **Basic set.** Bank=0x00, request 0x05 → `set_enable` at positions 0 then 2 in cycles 1–2, no clears, `done` in cycle 5 (SETTLE=1), `busy` high in cycles 1–4.
- **Mixed parallel.** Bank=0xF0, request 0x0F → set 0,1,2,3 in parallel with clear 4,5,6,7, one pair per cycle over 4 cycles, `done` in cycle 7.
- **No-op.** Bank=0x3C, request 0x3C → one ISSUE cycle with no strobes, `done` in cycle 4.
- **Retry.** The bench model drops the set of position 6 once for request 0x40 → first CHECK fails, a second set of position 6 is issued, `done` is asserted and `error` stays 0.
- **Exhaustion.** The bench bank ignores all commands, request 0x01, `MAX_RETRY`=2 → exactly 3 set strobes at position 0, a single `error` pulse, `done` never asserted.
- **Reset mid-operation.** Request 0xFF from 0x00, assert `clr` in cycle 3 → strobes stop from cycle 4, `busy`=0, no `done`/`error`; `req_ready`=1 and a new request is accepted immediately.
